// File: rtl/adder_sub_bist_pkg.sv
// adder_sub_bist_pkg
// Shared definitions for the 4-bit add/sub BIST controller:
//   VEC_W / NUM_VEC : vector index width and sweep length
//   ERR_W           : error counter width (saturating)
//   state_t         : controller FSM states
package adder_sub_bist_pkg;

  localparam int unsigned VEC_W   = 9;
  localparam int unsigned NUM_VEC = 512;
  localparam int unsigned ERR_W   = 10;

  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/adder_sub_ref.sv
// adder_sub_ref
// Combinational golden model of the 4-bit adder/subtractor under test.
//   a, b : operands (bit 3 = MSB)
//   m    : 0 = add, 1 = subtract (a + ~b + 1)
//   s    : 4-bit result
//   c4   : carry-out (for subtract, 1 means no borrow)
//   v    : two's-complement overflow
module adder_sub_ref (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  output logic [3:0] s,
  output logic       c4,
  output logic       v
);

  logic [3:0] b_eff;
  logic [4:0] sum;

  always_comb begin
    b_eff = m ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, m};
    s     = sum[3:0];
    c4    = sum[4];
    if (m) v = (a[3] != b[3]) && (s[3] != a[3]);
    else   v = (a[3] == b[3]) && (s[3] != a[3]);
  end

endmodule

// File: rtl/adder_sub_bist.sv
// adder_sub_bist
// Exhaustive BIST sweep of an external 4-bit add/sub unit (512 vectors).
// Parameter SETTLE_CYCLES (1..15): idle cycles between drive and sample.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin a sweep (honoured in IDLE or DONE only)
//   busy, done, pass     : sweep status; pass is valid while done is high
//   err_count            : mismatching vectors in current/last sweep (saturating)
//   dut_a, dut_b, dut_m  : operands/mode driven to the unit
//   dut_s, dut_c4, dut_v : result returned by the unit
// Optional macro BIST_FAIL_CAPTURE_EN adds fail_valid/fail_vec, the index of
// the first mismatching vector of the sweep.
module adder_sub_bist
  import adder_sub_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       dut_a,
  output logic [3:0]       dut_b,
  output logic             dut_m,
  input  logic [3:0]       dut_s,
  input  logic             dut_c4,
  input  logic             dut_v
`ifdef BIST_FAIL_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
`endif
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [VEC_W-1:0] idx;
  logic [3:0]       settle_cnt;
  logic             start_acc;
  logic             check_en;
  logic             last_vec;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  logic [3:0]       exp_s;
  logic             exp_c4;
  logic             exp_v;

  adder_sub_ref u_ref (
    .a  (dut_a),
    .b  (dut_b),
    .m  (dut_m),
    .s  (exp_s),
    .c4 (exp_c4),
    .v  (exp_v)
  );

  // Operands come straight from the index register, so they stay stable
  // from APPLY through CHECK and read as zero under reset.
  assign dut_a = idx[3:0];
  assign dut_b = idx[7:4];
  assign dut_m = idx[8];
  assign busy  = (state_q == ST_APPLY) || (state_q == ST_SETTLE) ||
                 (state_q == ST_CHECK);

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    check_en  = 1'b0;
    last_vec  = (idx == VEC_LAST);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_APPLY;
          start_acc = 1'b1;
        end
      end
      ST_APPLY:  state_d = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_d = ST_CHECK;
      ST_CHECK: begin
        check_en = 1'b1;
        state_d  = last_vec ? ST_DONE : ST_APPLY;
      end
      default:   state_d = ST_IDLE;
    endcase

    mismatch = ({dut_s, dut_c4, dut_v} != {exp_s, exp_c4, exp_v});
    err_next = err_count;
    if (check_en && mismatch && (err_count != ERR_MAX))
      err_next = err_count + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        idx        <= '0;
        settle_cnt <= '0;
        err_count  <= '0;
        done       <= 1'b0;
        pass       <= 1'b0;
      end else begin
        if (state_q == ST_APPLY)       settle_cnt <= '0;
        else if (state_q == ST_SETTLE) settle_cnt <= settle_cnt + 4'd1;
        if (check_en) begin
          err_count <= err_next;
          // pass uses err_next so the final vector's result is included
          if (last_vec) begin
            done <= 1'b1;
            pass <= (err_next == '0);
          end else begin
            idx <= idx + VEC_W'(1);
          end
        end
      end
    end
  end

`ifdef BIST_FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (start_acc) begin
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (check_en && mismatch && !fail_valid) begin
      fail_valid <= 1'b1;
      fail_vec   <= idx;
    end
  end
`endif

endmodule

// File: tb/tb_adder_sub_bist.sv
// tb_adder_sub_bist
// Self-checking bench for adder_sub_bist. The bench plays the role of the
// attached add/sub unit; faults (stuck bits, per-vector overrides) are
// injected into it and the expected BIST verdict is derived from an
// arithmetic model of the unit.
module tb_adder_sub_bist;
  import adder_sub_bist_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       dut_a, dut_b, dut_s;
  logic             dut_m, dut_c4, dut_v;
`ifdef BIST_FAIL_CAPTURE_EN
  logic             fail_valid;
  logic [VEC_W-1:0] fail_vec;
`endif

  always #5 clk = ~clk;

  adder_sub_bist #(.SETTLE_CYCLES(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_m     (dut_m),
    .dut_s     (dut_s),
    .dut_c4    (dut_c4),
    .dut_v     (dut_v)
`ifdef BIST_FAIL_CAPTURE_EN
    ,
    .fail_valid(fail_valid),
    .fail_vec  (fail_vec)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Unit fault configuration: 0 healthy, 1 s0 stuck-at-0, 2 v stuck-at-0
  int         fault_mode = 0;
  bit         ovr_en  [512];
  logic [5:0] ovr_val [512];
  int         cfg_rev = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       m;
    logic [3:0] s;
    logic       c4;
    logic       v;
  } spot_t;

  // Arithmetic model of a correct unit: {s[3:0], c4, v}
  function automatic logic [5:0] golden(input int i);
    int a, b, m, sa, sb, raw, r;
    logic [3:0] s;
    logic c4, v;
    a   = i % 16;
    b   = (i / 16) % 16;
    m   = i / 256;
    sa  = (a >= 8) ? a - 16 : a;
    sb  = (b >= 8) ? b - 16 : b;
    raw = (m != 0) ? a + 16 - b : a + b;
    r   = (m != 0) ? sa - sb : sa + sb;
    s   = 4'(raw % 16);
    c4  = (raw >= 16);
    v   = (r > 7) || (r < -8);
    return {s, c4, v};
  endfunction

  function automatic logic [5:0] faulty(input int i);
    logic [5:0] val;
    val = ovr_en[i] ? ovr_val[i] : golden(i);
    if (fault_mode == 1) val[2] = 1'b0;
    if (fault_mode == 2) val[0] = 1'b0;
    return val;
  endfunction

  always @(dut_a, dut_b, dut_m, cfg_rev)
    {dut_s, dut_c4, dut_v} = faulty(int'({dut_m, dut_b, dut_a}));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_cfg();
    fault_mode = 0;
    for (int i = 0; i < 512; i++) ovr_en[i] = 1'b0;
    cfg_rev++;
  endtask

  // Expected BIST result: count of vectors where the unit disagrees with
  // correct arithmetic, and the first such vector.
  task automatic compute_exp(output int e, output int first);
    e = 0;
    first = -1;
    for (int i = 0; i < 512; i++) begin
      if (faulty(i) != golden(i)) begin
        e++;
        if (first < 0) first = i;
      end
    end
    if (e > 1023) e = 1023;
  endtask

  task automatic run_sweep(input string tag, input bit poke_start);
    int cycles, e, first;
    compute_exp(e, first);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, " busy after start"}, 32'(busy), 1);
    chk({tag, " done cleared"}, 32'(done), 0);
    chk({tag, " err cleared"}, 32'(err_count), 0);
    cycles = 0;
    while (busy && cycles < 5000) begin
      cycles++;
      if (poke_start) start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " busy cycles"}, 32'(cycles), 1536);
    chk({tag, " done"}, 32'(done), 1);
    chk({tag, " pass"}, 32'(pass), 32'(e == 0));
    chk({tag, " err_count"}, 32'(err_count), 32'(e));
`ifdef BIST_FAIL_CAPTURE_EN
    chk({tag, " fail_valid"}, 32'(fail_valid), 32'(e != 0));
    if (e != 0) chk({tag, " fail_vec"}, 32'(fail_vec), 32'(first));
`endif
    // DONE must hold without a new start
    repeat (3) @(negedge clk);
    chk({tag, " done held"}, 32'({done, busy}), 32'b10);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    spot_t spots [3];
    int    vi, cnt, nk;

    spots[0] = '{a: 4'b0101, b: 4'b0011, m: 1'b1, s: 4'b0010, c4: 1'b1, v: 1'b0};
    spots[1] = '{a: 4'b0100, b: 4'b1001, m: 1'b1, s: 4'b1011, c4: 1'b0, v: 1'b1};
    spots[2] = '{a: 4'b1100, b: 4'b0111, m: 1'b0, s: 4'b0011, c4: 1'b1, v: 1'b0};

    clear_cfg();

    // Reset state (asynchronous, before any clock edge matters)
    #12;
    chk("reset outputs", 32'({busy, done, pass, err_count, dut_a, dut_b, dut_m}), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", 32'({busy, done, pass}), 0);

    // Healthy unit
    run_sweep("clean", 1'b0);

    // s0 stuck-at-0; start from DONE must clear the previous verdict
    clear_cfg();
    fault_mode = 1;
    cfg_rev++;
    run_sweep("s0sa0", 1'b0);
    chk("s0sa0 err 256", 32'(err_count), 256);
`ifdef BIST_FAIL_CAPTURE_EN
    chk("s0sa0 fail_vec 1", 32'(fail_vec), 1);
`endif

    // v stuck-at-0: errors equal the number of overflowing vectors
    clear_cfg();
    fault_mode = 2;
    cfg_rev++;
    run_sweep("vsa0", 1'b0);
    chk("vsa0 pass low", 32'(pass), 0);

    // Spot vectors: the table's values must be accepted, a one-bit
    // deviation at that vector must be the only error.
    for (int k = 0; k < 3; k++) begin
      clear_cfg();
      vi = int'({spots[k].m, spots[k].b, spots[k].a});
      ovr_en[vi]  = 1'b1;
      ovr_val[vi] = {spots[k].s, spots[k].c4, spots[k].v};
      cfg_rev++;
      run_sweep($sformatf("spot%0d ok", k), 1'b0);
      chk($sformatf("spot%0d ok err", k), 32'(err_count), 0);
      ovr_val[vi] = {spots[k].s, spots[k].c4, spots[k].v} ^ 6'b000010;
      cfg_rev++;
      run_sweep($sformatf("spot%0d bad", k), 1'b0);
      chk($sformatf("spot%0d bad err", k), 32'(err_count), 1);
`ifdef BIST_FAIL_CAPTURE_EN
      chk($sformatf("spot%0d bad vec", k), 32'(fail_vec), 32'(vi));
`endif
    end

    // start hammered while busy must not restart or stretch the sweep
    clear_cfg();
    run_sweep("start poke", 1'b1);

    // Randomised corruption sets
    for (int r = 0; r < 4; r++) begin
      clear_cfg();
      nk = $urandom_range(0, 12);
      for (int k = 0; k < nk; k++) begin
        vi = $urandom_range(0, 511);
        ovr_en[vi]  = 1'b1;
        ovr_val[vi] = golden(vi) ^ 6'($urandom_range(1, 63));
      end
      if ($urandom_range(0, 3) == 0) fault_mode = $urandom_range(1, 2);
      cfg_rev++;
      run_sweep($sformatf("rand%0d", r), 1'b0);
    end

    // Reset in the middle of a sweep at vector 200
    clear_cfg();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt = 0;
    while (int'({dut_m, dut_b, dut_a}) != 200 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    chk("reached vector 200", 32'({dut_m, dut_b, dut_a}), 200);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", 32'({busy, done, pass, err_count, dut_a, dut_b, dut_m}), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abandoned sweep idle", 32'({busy, done, pass}), 0);
    run_sweep("after reset", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
